token_run_counter: RTL and testbench

//  Downstream stage of the serial token doubler. Measures the length of each
//  run of consecutive '1' tokens on a serial bit stream.

---
 rtl/token_pkg.sv | 11 +
 rtl/token_run_counter_if.sv | 14 +
 rtl/token_run_fifo.sv | 62 ++++++
 rtl/token_run_counter.sv | 85 ++++++++
 tb/tb_token_run_counter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/token_pkg.sv
// Shared types for the serial token run counter: run record layout and defaults.
package token_pkg;

    localparam int RUN_W_DEF = 9;

    typedef struct packed {
        logic                 sat;
        logic [RUN_W_DEF-1:0] len;
    } run_rec_t;

endpackage

// File: rtl/token_run_counter_if.sv
// Run record handshake between the run counter and its consumer.
// valid/ready: a record transfers on a clock edge where run_valid and run_ready
// are both high; while run_valid is high and run_ready low, run_len/run_sat hold.
interface token_run_counter_if #(
    parameter int RUN_W = 9
);
    logic [RUN_W-1:0] run_len;
    logic             run_sat;
    logic             run_valid;
    logic             run_ready;

    modport master (output run_len, output run_sat, output run_valid, input run_ready);
    modport slave  (input run_len, input run_sat, input run_valid, output run_ready);
endinterface

// File: rtl/token_run_fifo.sv
// Synchronous FIFO of run records with a registered head; a push into an empty
// FIFO is visible at the head on the following cycle.
module token_run_fifo
    import token_pkg::*;
#(
    parameter type rec_t = run_rec_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rec_t          din,
    input  logic          pop,
    output rec_t          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          last_one;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign last_one = (count == CW'(1));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Head reloads from the incoming record when it would be the only entry.
            if (do_push && (empty || (do_pop && last_one)))
                head <= din;
            else if (do_pop)
                head <= last_one ? '0 : mem[rd_ptr + AW'(1)];
        end
    end

endmodule

// File: rtl/token_run_counter.sv
// Measures runs of consecutive '1' tokens and queues {sat, length} records
// for a valid/ready consumer; lost records set a sticky drop flag.
module token_run_counter
    import token_pkg::*;
#(
    parameter int RUN_W      = RUN_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tok,
    input  logic                            flush,
    token_run_counter_if.master             rec,
    output logic                            drop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill
);

    typedef struct packed {
        logic             sat;
        logic [RUN_W-1:0] len;
    } rec_t;

    localparam logic [RUN_W-1:0] MAX_LEN = '1;

    logic [RUN_W-1:0] cnt;
    logic             sat;
    logic             cnt_max;
    logic             close;
    logic             pop;
    logic             full;
    logic             empty;
    rec_t             rec_in;
    rec_t             head;

    assign cnt_max = (cnt == MAX_LEN);
    assign close   = (!tok && (cnt != '0)) || (flush && ((cnt != '0) || tok));
    assign pop     = rec.run_valid && rec.run_ready;

    // A flush counts the current token as part of the closing run.
    always_comb begin
        rec_in.len = cnt;
        rec_in.sat = sat;
        if (flush && tok) begin
            if (cnt_max) rec_in.sat = 1'b1;
            else         rec_in.len = cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sat  <= 1'b0;
            drop <= 1'b0;
        end else begin
            if (close) begin
                cnt <= '0;
                sat <= 1'b0;
            end else if (tok) begin
                if (cnt_max) sat <= 1'b1;
                else         cnt <= cnt + RUN_W'(1);
            end
            if (close && full && !pop) drop <= 1'b1;
        end
    end

    token_run_fifo #(
        .rec_t (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (close),
        .din   (rec_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fill)
    );

    assign rec.run_len   = head.len;
    assign rec.run_sat   = head.sat;
    assign rec.run_valid = !empty;

endmodule

// File: tb/tb_token_run_counter.sv
// Bench for token_run_counter: table vectors, hand sequences and a queue scoreboard.
module tb_token_run_counter;
    import token_pkg::*;

    localparam int RUN_W   = 9;
    localparam int DEPTH   = 4;
    localparam int W       = RUN_W + 1;
    localparam int MAX_LEN = 511;

    logic       clk = 1'b0;
    logic       rst;
    logic       tok;
    logic       flush;
    logic       drop;
    logic [2:0] fill;

    token_run_counter_if #(.RUN_W(RUN_W)) bus ();

    token_run_counter #(
        .RUN_W      (RUN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tok   (tok),
        .flush (flush),
        .rec   (bus.master),
        .drop  (drop),
        .fill  (fill)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard state: expected FIFO contents {sat, len} plus reference counter
    logic [W-1:0] exp_q[$];
    int           m_cnt;
    bit           m_sat;
    bit           m_drop;

    typedef struct {
        bit tok;
        bit flush;
        bit ready;
        bit v;
        int len;
        bit sat;
        int fill;
        bit drop;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update(input bit t, input bit f, input bit r);
        bit pop;
        bit close;
        int len;
        bit s;
        logic [W-1:0] item;
        pop   = (exp_q.size() != 0) && r;
        close = (!t && m_cnt > 0) || (f && (m_cnt + int'(t)) > 0);
        len   = f ? m_cnt + int'(t) : m_cnt;
        s     = m_sat;
        if (len > MAX_LEN) begin
            len = MAX_LEN;
            s   = 1'b1;
        end
        if (pop) void'(exp_q.pop_front());
        if (close) begin
            item = {s, len[RUN_W-1:0]};
            if (exp_q.size() < DEPTH) exp_q.push_back(item);
            else                      m_drop = 1'b1;
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (t) begin
            if (m_cnt == MAX_LEN) m_sat = 1'b1;
            else                  m_cnt++;
        end
    endtask

    // driver: compare outputs against the scoreboard, then drive the next cycle
    task automatic step(input bit t, input bit f, input bit r);
        @(negedge clk);
        check("sb_valid", bus.run_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("sb_head", {bus.run_sat, bus.run_len}, exp_q[0]);
        check("sb_fill", fill, exp_q.size());
        check("sb_drop", drop, m_drop);
        tok           = t;
        flush         = f;
        bus.run_ready = r;
        model_update(t, f, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        tok           = 1'b0;
        flush         = 1'b0;
        bus.run_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_cnt  = 0;
        m_sat  = 1'b0;
        m_drop = 1'b0;
        check("rst_valid", bus.run_valid, 0);
        check("rst_len", bus.run_len, 0);
        check("rst_sat", bus.run_sat, 0);
        check("rst_drop", drop, 0);
        check("rst_fill", fill, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        tok           = 1'b0;
        flush         = 1'b0;
        bus.run_ready = 1'b0;

        // tok=0110111000 with ready=1; expected outputs after each edge
        tbl[0] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 1, 2, 0, 1, 0};
        tbl[4] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 1, 3, 0, 1, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[9] = '{0, 0, 1, 0, 0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].tok, tbl[i].flush, tbl[i].ready);
            after_edge();
            check("tbl_valid", bus.run_valid, tbl[i].v);
            check("tbl_fill", fill, tbl[i].fill);
            check("tbl_drop", drop, tbl[i].drop);
            if (tbl[i].v) begin
                check("tbl_len", bus.run_len, tbl[i].len);
                check("tbl_sat", bus.run_sat, tbl[i].sat);
            end
        end

        // longest unsaturated run, then an oversized one
        do_reset();
        repeat (511) step(1, 0, 1);
        step(0, 0, 1);
        after_edge();
        check("len511_valid", bus.run_valid, 1);
        check("len511_len", bus.run_len, 511);
        check("len511_sat", bus.run_sat, 0);
        step(0, 0, 1);
        repeat (600) step(1, 0, 1);
        step(0, 0, 1);
        after_edge();
        check("len600_len", bus.run_len, 511);
        check("len600_sat", bus.run_sat, 1);

        // overfill with ready low, then drain in order
        do_reset();
        repeat (5) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        after_edge();
        check("full_fill", fill, 4);
        check("full_drop", drop, 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.run_valid, 1);
            check("drain_len", bus.run_len, 1);
            step(0, 0, 1);
            after_edge();
        end
        check("drained_valid", bus.run_valid, 0);
        check("drained_fill", fill, 0);
        check("drained_drop", drop, 1);

        // full FIFO with a pop in the closing cycle keeps the record
        do_reset();
        repeat (4) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        step(1, 0, 0);
        step(0, 0, 1);
        after_edge();
        check("pushpop_fill", fill, 4);
        check("pushpop_drop", drop, 0);
        repeat (5) step(0, 0, 1);

        // flush includes the current token; empty flush is silent
        do_reset();
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        after_edge();
        check("flush_valid", bus.run_valid, 1);
        check("flush_len", bus.run_len, 3);
        check("flush_sat", bus.run_sat, 0);
        step(0, 1, 1);
        after_edge();
        check("flush0_valid", bus.run_valid, 0);
        check("flush0_fill", fill, 0);
        step(0, 1, 1);
        after_edge();
        check("flush0b_fill", fill, 0);

        // reset mid-run discards the partial run
        do_reset();
        repeat (3) step(1, 0, 1);
        do_reset();
        step(0, 0, 1);
        step(0, 0, 1);
        after_edge();
        check("midrst_valid", bus.run_valid, 0);
        check("midrst_fill", fill, 0);
        check("midrst_drop", drop, 0);
        step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
